maxpool_unit: RTL and testbench
===============================

Name: maxpool_unit

Overview:
- 2x2, stride-2 signed max-pooling engine; it is the stage run while the layer controller holds `pool` high.
- Reads the convolution result map from a single-port feature buffer with synchronous read (1-cycle latency).
- Writes the pooled map to an output buffer in raster order.
- Returns a level `pool_done` to the controller, which uses it to move to STOP.

Parameters:
- DATA_W, 16, width of feature elements (two's complement).
- FM_W, 26, input feature-map width in elements.
- FM_H, 26, input feature-map height in elements.
- RD_ADDR_W, 10, input buffer address width; must satisfy 2^RD_ADDR_W >= FM_W*FM_H.
- WR_ADDR_W, 8, output buffer address width; must satisfy 2^WR_ADDR_W >= (FM_W/2)*(FM_H/2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pool  in  1  level enable from the layer controller; high = run/continue.
- rd_en  out  1  input buffer read strobe.
- rd_addr  out  RD_ADDR_W  input buffer address, row*FM_W+col.
- rd_data  in  DATA_W  input buffer data, valid the cycle after rd_en.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  WR_ADDR_W  output buffer address.
- wr_data  out  DATA_W  pooled value.
- pool_done  out  1  level; high while in DONE.

Behaviour:
- Output map: OW=FM_W/2, OH=FM_H/2 (integer floor). An odd trailing column/row is never read.
- Windows are processed in raster order (orow 0..OH-1, ocol 0..OW-1). wr_addr counts 0..OW*OH-1 sequentially.
- FSM states: IDLE, RD, DRAIN, WR, DONE. Reset state is IDLE.
  - IDLE: if pool=1, go to RD with k=0 and window counters cleared.
  - RD: 4 cycles, k=0..3.
    - rd_en=1 each cycle.
    - Addresses, in order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
    - After k=3, go to DRAIN.
  - DRAIN: 1 cycle, no read; captures the k=3 data. Then go to WR.
  - WR: 1 cycle; wr_en=1, wr_data=max register.
    - If this is the last window, go to DONE.
    - Otherwise advance ocol (wrap to 0 and increment orow at OW-1), then go to RD.
  - DONE: pool_done=1; stay in DONE while pool=1; go to IDLE when pool=0.
- Max register:
  - In the cycle after k=0 is issued, it is loaded with rd_data.
  - In the cycles after k=1..3, it is replaced only if rd_data > max (signed compare).
  - On equal values the earlier value is kept.
- Addresses come from incrementally maintained row-base registers (add FM_W / 2*FM_W). No multiplier.
- Timing: each window takes exactly 6 cycles.
  - Cycle 0 = the edge at which IDLE samples pool=1.
  - Window n occupies cycles 1+6n..6+6n, with its write in cycle 6+6n.
  - pool_done rises in cycle 1+6*OW*OH.
- Outputs are registered or decoded from state. Values in reset and IDLE:
  - rd_en=0, wr_en=0, pool_done=0.
  - rd_addr=0, wr_addr=0, wr_data=0.
- Abort: pool=0 in RD, DRAIN or WR.
  - Go to IDLE on the next edge; all counters clear.
  - No write is issued in a WR cycle where pool=0.
  - pool_done is not asserted.
  - A later pool=1 restarts from window 0.
- rst_n asserted at any time: immediate return to IDLE with reset output values. No partial write completes.
- pool=1 continuously after DONE→IDLE is impossible, because DONE only exits on pool=0. No restart without pool going low first.
- rd_data is ignored outside the cycle following an rd_en.

Test Plan:
- 4x4 map, values 0..15 row-major; pool held high until pool_done.
  - Writes (addr,data): (0,5), (1,7), (2,13), (3,15) in cycles 6, 12, 18, 24.
  - pool_done=1 from cycle 25.
  - rd_addr sequence for window 0 is 0,1,4,5.
- 2x2 window {-7,-3,-9,-3} (FM_W=FM_H=2) → single write, wr_data=-3 (0xFFFD), wr_addr=0.
  - Also with {-32768,-32768,-32768,-32768} → -32768.
- 5x5 map, values 0..24 → 4 writes of 6, 8, 16, 18.
  - rd_addr never equals 4, 9, 14 or 20..24.
- Abort: 4x4 map, drop pool at cycle 9 (window 1, RD).
  - No write with wr_addr=1.
  - pool_done stays 0.
  - Re-raise pool: a full run matching the first test, restarting at wr_addr=0.
- DONE handshake: after pool_done=1, hold pool high 5 cycles → pool_done stays 1 and there are no extra reads/writes.
  - Drop pool → pool_done=0 next cycle.
- Reset mid-operation: assert rst_n low asynchronously at cycle 15.
  - All outputs reach 0 immediately.
  - After release with pool=1, a complete correct run follows.

Source files
------------

// File: rtl/maxpool_unit.sv
`default_nettype none
// ============================================================================
// maxpool_unit : 2x2 stride-2 signed max-pooling over a synchronous-read buffer
// Revision     : 1.0
// ============================================================================
module maxpool_unit #(
    parameter int DATA_W    = 16,
    parameter int FM_W      = 26,
    parameter int FM_H      = 26,
    parameter int RD_ADDR_W = 10,
    parameter int WR_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pool,
    output logic                 rd_en,
    output logic [RD_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 wr_en,
    output logic [WR_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 pool_done
);

    localparam int OW = FM_W / 2;
    localparam int OH = FM_H / 2;
    localparam int CW = $clog2(OW + 1);
    localparam int RW = $clog2(OH + 1);

    localparam logic [CW-1:0]        OCOL_LAST = CW'(OW - 1);
    localparam logic [RW-1:0]        OROW_LAST = RW'(OH - 1);
    localparam logic [RD_ADDR_W-1:0] ROW_STEP  = RD_ADDR_W'(2 * FM_W);
    localparam logic [RD_ADDR_W-1:0] ROW1_INIT = RD_ADDR_W'(FM_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [CW-1:0]          ocol_q, ocol_d;
    logic [RW-1:0]          orow_q, orow_d;
    logic [RD_ADDR_W-1:0]   row0_q, row0_d;   // base of window's upper row
    logic [RD_ADDR_W-1:0]   row1_q, row1_d;   // base of window's lower row
    logic [RD_ADDR_W-1:0]   col_q, col_d;     // 2*ocol
    logic [WR_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      max_q, max_d;
    logic                   last_win;

    always_comb begin
        last_win = (ocol_q == OCOL_LAST) && (orow_q == OROW_LAST);
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ocol_d    = ocol_q;
        orow_d    = orow_q;
        row0_d    = row0_q;
        row1_d    = row1_q;
        col_d     = col_q;
        wr_addr_d = wr_addr_q;
        max_d     = max_q;

        case (state_q)
            ST_IDLE: begin
                if (pool) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (!pool) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = pool ? ST_WR : ST_IDLE;
            end
            ST_WR: begin
                if (!pool) begin
                    state_d = ST_IDLE;
                end else if (last_win) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_RD;
                    k_d       = 2'd0;
                    wr_addr_d = wr_addr_q + WR_ADDR_W'(1);
                    if (ocol_q == OCOL_LAST) begin
                        ocol_d = '0;
                        col_d  = '0;
                        orow_d = orow_q + RW'(1);
                        row0_d = row0_q + ROW_STEP;
                        row1_d = row1_q + ROW_STEP;
                    end else begin
                        ocol_d = ocol_q + CW'(1);
                        col_d  = col_q + RD_ADDR_W'(2);
                    end
                end
            end
            ST_DONE: begin
                if (!pool) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Data returns one cycle after its read: k=0 lands while k=1 is issued.
        if (state_q == ST_RD && k_q == 2'd1) begin
            max_d = rd_data;
        end else if ((state_q == ST_RD && k_q[1]) || state_q == ST_DRAIN) begin
            if ($signed(rd_data) > $signed(max_q)) begin
                max_d = rd_data;
            end
        end

        // Entering IDLE (abort or finish) always restarts from window 0.
        if (state_d == ST_IDLE) begin
            k_d       = 2'd0;
            ocol_d    = '0;
            orow_d    = '0;
            row0_d    = '0;
            row1_d    = ROW1_INIT;
            col_d     = '0;
            wr_addr_d = '0;
            max_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= 2'd0;
            ocol_q    <= '0;
            orow_q    <= '0;
            row0_q    <= '0;
            row1_q    <= ROW1_INIT;
            col_q     <= '0;
            wr_addr_q <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ocol_q    <= ocol_d;
            orow_q    <= orow_d;
            row0_q    <= row0_d;
            row1_q    <= row1_d;
            col_q     <= col_d;
            wr_addr_q <= wr_addr_d;
            max_q     <= max_d;
        end
    end

    always_comb begin
        rd_en     = (state_q == ST_RD);
        rd_addr   = '0;
        if (rd_en) begin
            rd_addr = (k_q[1] ? row1_q : row0_q) + col_q
                    + {{(RD_ADDR_W-1){1'b0}}, k_q[0]};
        end
        wr_en     = (state_q == ST_WR) && pool;
        wr_addr   = wr_addr_q;
        wr_data   = (state_q == ST_WR) ? max_q : '0;
        pool_done = (state_q == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_unit.sv
`default_nettype none
// ============================================================================
// tb_maxpool_unit : checks 4x4, 2x2 and 5x5 instances against window-max model
// Revision        : 1.0
// ============================================================================
module tb_maxpool_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic pool4 = 1'b0, pool2 = 1'b0, pool5 = 1'b0;

    logic rd_en4, wr_en4, done4;
    logic [9:0] rd_addr4;
    logic [7:0] wr_addr4;
    logic [15:0] rd_data4, wr_data4;
    logic rd_en2, wr_en2, done2;
    logic [9:0] rd_addr2;
    logic [7:0] wr_addr2;
    logic [15:0] rd_data2, wr_data2;
    logic rd_en5, wr_en5, done5;
    logic [9:0] rd_addr5;
    logic [7:0] wr_addr5;
    logic [15:0] rd_data5, wr_data5;

    logic [15:0] mem4 [16];
    logic [15:0] mem2 [4];
    logic [15:0] mem5 [25];

    maxpool_unit #(.DATA_W(16), .FM_W(4), .FM_H(4), .RD_ADDR_W(10), .WR_ADDR_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .pool(pool4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .pool_done(done4));
    maxpool_unit #(.DATA_W(16), .FM_W(2), .FM_H(2), .RD_ADDR_W(10), .WR_ADDR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .pool(pool2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .pool_done(done2));
    maxpool_unit #(.DATA_W(16), .FM_W(5), .FM_H(5), .RD_ADDR_W(10), .WR_ADDR_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .pool(pool5), .rd_en(rd_en5), .rd_addr(rd_addr5),
        .rd_data(rd_data5), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .pool_done(done5));

    // Synchronous-read buffers; data is scrambled when no read was issued.
    always @(posedge clk) begin
        rd_data4 <= (rd_en4 && rd_addr4 < 16) ? mem4[rd_addr4[3:0]] : 16'($urandom);
        rd_data2 <= (rd_en2 && rd_addr2 < 4)  ? mem2[rd_addr2[1:0]] : 16'($urandom);
        rd_data5 <= (rd_en5 && rd_addr5 < 25) ? mem5[rd_addr5[4:0]] : 16'($urandom);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wq[$];
    int  base = 0, act = 4, rd_cnt = 0, bad_rd = 0;
    int  n_cmp = 0, n_bad = 0;

    always @(negedge clk) begin
        logic we, re;
        int wa, wd, ra;
        case (act)
            2:       begin we = wr_en2; wa = int'(wr_addr2); wd = int'($signed(wr_data2)); re = rd_en2; ra = int'(rd_addr2); end
            5:       begin we = wr_en5; wa = int'(wr_addr5); wd = int'($signed(wr_data5)); re = rd_en5; ra = int'(rd_addr5); end
            default: begin we = wr_en4; wa = int'(wr_addr4); wd = int'($signed(wr_data4)); re = rd_en4; ra = int'(rd_addr4); end
        endcase
        if (we) wq.push_back('{wa, wd, cyc - base});
        if (re) rd_cnt++;
        if (act == 5 && re && ((ra % 5) == 4 || ra >= 20)) bad_rd++;
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    function automatic int getv(input int inst, input int idx);
        case (inst)
            2:       return int'($signed(mem2[idx]));
            5:       return int'($signed(mem5[idx]));
            default: return int'($signed(mem4[idx]));
        endcase
    endfunction

    // Reference: plain max over the four elements of each window.
    function automatic int win_max(input int inst, input int w, input int r, input int c);
        int m = getv(inst, 2 * r * w + 2 * c);
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (getv(inst, (2 * r + dr) * w + 2 * c + dc) > m)
                    m = getv(inst, (2 * r + dr) * w + 2 * c + dc);
        return m;
    endfunction

    task automatic set_pool(input int inst, input logic v);
        case (inst)
            2:       pool2 = v;
            5:       pool5 = v;
            default: pool4 = v;
        endcase
    endtask

    function automatic int done_of(input int inst);
        case (inst)
            2:       return int'(done2);
            5:       return int'(done5);
            default: return int'(done4);
        endcase
    endfunction

    task automatic clear_logs(input int inst);
        act = inst;
        wq.delete();
        rd_cnt = 0;
        bad_rd = 0;
    endtask

    task automatic check_writes(input int inst, input int w, input int h, input string tag);
        int ow = w / 2;
        int nw = (w / 2) * (h / 2);
        chk({tag, " write count"}, wq.size(), nw);
        for (int n = 0; n < nw && n < wq.size(); n++) begin
            chk({tag, " wr_addr"}, wq[n].addr, n);
            chk({tag, " wr_data"}, wq[n].data, win_max(inst, w, n / ow, n % ow));
            chk({tag, " wr cycle"}, wq[n].cyc, 6 + 6 * n);
        end
    endtask

    // Full run with pool held high, then the DONE handshake.
    task automatic run(input int inst, input int w, input int h, input string tag);
        int nw = (w / 2) * (h / 2);
        int t = 0, rc, wc;
        clear_logs(inst);
        @(negedge clk);
        base = cyc;
        set_pool(inst, 1'b1);
        while (done_of(inst) == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " done cycle"}, cyc - base, 1 + 6 * nw);
        check_writes(inst, w, h, tag);
        chk({tag, " read count"}, rd_cnt, 4 * nw);
        rc = rd_cnt;
        wc = wq.size();
        repeat (5) begin
            @(negedge clk);
            chk({tag, " done held"}, done_of(inst), 1);
        end
        chk({tag, " no extra reads"}, rd_cnt, rc);
        chk({tag, " no extra writes"}, wq.size(), wc);
        set_pool(inst, 1'b0);
        @(negedge clk);
        chk({tag, " done drop"}, done_of(inst), 0);
    endtask

    typedef struct {
        int cyc; logic rd_en; int rd_addr; logic wr_en; int wr_addr; int wr_data; logic done;
    } vec_t;
    vec_t tbl[$];

    // 4x4 ramp run, cycle by cycle against the table; also releases reset.
    task automatic run_table(input string tag);
        for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
        clear_logs(4);
        @(negedge clk);
        base = cyc;
        pool4 = 1'b1;
        rst_n = 1'b1;
        for (int rel = 1; rel <= 26; rel++) begin
            @(negedge clk);
            foreach (tbl[j]) begin
                if (tbl[j].cyc == rel) begin
                    chk($sformatf("%s c%0d rd_en", tag, rel), int'(rd_en4), int'(tbl[j].rd_en));
                    if (tbl[j].rd_en)
                        chk($sformatf("%s c%0d rd_addr", tag, rel), int'(rd_addr4), tbl[j].rd_addr);
                    chk($sformatf("%s c%0d wr_en", tag, rel), int'(wr_en4), int'(tbl[j].wr_en));
                    if (tbl[j].wr_en) begin
                        chk($sformatf("%s c%0d wr_addr", tag, rel), int'(wr_addr4), tbl[j].wr_addr);
                        chk($sformatf("%s c%0d wr_data", tag, rel), int'($signed(wr_data4)), tbl[j].wr_data);
                    end
                    chk($sformatf("%s c%0d pool_done", tag, rel), int'(done4), int'(tbl[j].done));
                end
            end
        end
        chk({tag, " write count"}, wq.size(), 4);
        pool4 = 1'b0;
        @(negedge clk);
        chk({tag, " done drop"}, int'(done4), 0);
    endtask

    initial begin
        int aborted_w1, done_seen;
        tbl.push_back('{1,  1'b1, 0,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{2,  1'b1, 1,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{3,  1'b1, 4,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{4,  1'b1, 5,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{5,  1'b0, 0,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{6,  1'b0, 0,  1'b1, 0, 5,  1'b0});
        tbl.push_back('{7,  1'b1, 2,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{10, 1'b1, 7,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{12, 1'b0, 0,  1'b1, 1, 7,  1'b0});
        tbl.push_back('{13, 1'b1, 8,  1'b0, 0, 0,  1'b0});
        tbl.push_back('{18, 1'b0, 0,  1'b1, 2, 13, 1'b0});
        tbl.push_back('{19, 1'b1, 10, 1'b0, 0, 0,  1'b0});
        tbl.push_back('{22, 1'b1, 15, 1'b0, 0, 0,  1'b0});
        tbl.push_back('{24, 1'b0, 0,  1'b1, 3, 15, 1'b0});
        tbl.push_back('{25, 1'b0, 0,  1'b0, 0, 0,  1'b1});
        tbl.push_back('{26, 1'b0, 0,  1'b0, 0, 0,  1'b1});

        repeat (3) @(negedge clk);
        chk("reset rd_en", int'(rd_en4), 0);
        chk("reset rd_addr", int'(rd_addr4), 0);
        chk("reset wr_en", int'(wr_en4), 0);
        chk("reset wr_addr", int'(wr_addr4), 0);
        chk("reset wr_data", int'(wr_data4), 0);
        chk("reset pool_done", int'(done4) + int'(done2) + int'(done5), 0);

        // Ramp run; this also releases reset.
        run_table("ramp4x4");

        // Abort in window 1 (RD), then full restart.
        for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
        clear_logs(4);
        @(negedge clk);
        base = cyc;
        pool4 = 1'b1;
        repeat (9) @(negedge clk);
        pool4 = 1'b0;
        @(negedge clk);
        chk("abort idle rd_en", int'(rd_en4), 0);
        chk("abort idle wr_addr", int'(wr_addr4), 0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            done_seen += int'(done4);
        end
        aborted_w1 = 0;
        foreach (wq[j]) if (wq[j].addr == 1) aborted_w1++;
        chk("abort no write to addr 1", aborted_w1, 0);
        chk("abort write count", wq.size(), 1);
        chk("abort pool_done never", done_seen, 0);
        run_table("after-abort");

        // Asynchronous reset in the middle of window 2.
        clear_logs(4);
        @(negedge clk);
        base = cyc;
        pool4 = 1'b1;
        repeat (15) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst rd_en", int'(rd_en4), 0);
        chk("async rst rd_addr", int'(rd_addr4), 0);
        chk("async rst wr_en", int'(wr_en4), 0);
        chk("async rst wr_addr", int'(wr_addr4), 0);
        chk("async rst wr_data", int'(wr_data4), 0);
        chk("async rst pool_done", int'(done4), 0);
        repeat (2) @(negedge clk);
        chk("async rst write count", wq.size(), 2);
        run_table("after-reset");

        // 2x2 corner cases.
        mem2[0] = 16'hFFF9; mem2[1] = 16'hFFFD; mem2[2] = 16'hFFF7; mem2[3] = 16'hFFFD;
        run(2, 2, 2, "2x2 neg");
        if (wq.size() > 0) chk("2x2 neg value", wq[0].data, -3);
        for (int i = 0; i < 4; i++) mem2[i] = 16'h8000;
        run(2, 2, 2, "2x2 min");
        if (wq.size() > 0) chk("2x2 min value", wq[0].data, -32768);

        // 5x5 ramp: odd trailing row/column is never read.
        for (int i = 0; i < 25; i++) mem5[i] = 16'(i);
        run(5, 5, 5, "ramp5x5");
        chk("5x5 odd edge reads", bad_rd, 0);
        if (wq.size() == 4) begin
            chk("5x5 w0", wq[0].data, 6);
            chk("5x5 w3", wq[3].data, 18);
        end

        // Randomized contents, with small values mixed in to force ties.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++)
                mem4[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 3)) - 2);
            for (int i = 0; i < 25; i++)
                mem5[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 3)) - 2);
            for (int i = 0; i < 4; i++)
                mem2[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 3)) - 2);
            run(4, 4, 4, $sformatf("rand4x4 #%0d", it));
            run(5, 5, 5, $sformatf("rand5x5 #%0d", it));
            chk("rand5x5 odd edge reads", bad_rd, 0);
            run(2, 2, 2, $sformatf("rand2x2 #%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
